// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between requesters.
// Optional ARB_LOCK_EN adds a per-requester lock for atomic read-modify-write.
module mem_port_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*32-1:0]     wdata,
  input  logic [NUM_REQ*4-1:0]      wmask,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [31:0]               rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_wmask,
  input  logic [31:0]               mem_rdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

  if (MEM_LATENCY < 1) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LATENCY must be >= 1");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num
    $error("mem_port_arbiter: NUM_REQ must be 2..8");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wmask_q;
  logic [31:0]       rdata_q;

  logic              found;
  logic [IW-1:0]     win;
  logic [IW-1:0]     cand;
  logic              take;
  logic              locked;

`ifdef ARB_LOCK_EN
  logic lock_q;
  assign locked = lock_q & lock[owner_q];
`else
  assign locked = 1'b0;
`endif

  // first requester at or after rr_ptr; a held lock pins the previous owner
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (locked) begin
      found = req[owner_q];
      win   = owner_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    gnt      = '0;
    rvalid   = '0;
    mem_en   = 1'b0;
    take     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt[win] = 1'b1;
          take     = 1'b1;
          cnt_d    = '0;
          state_d  = ACCESS;
          if (!locked)
            rr_ptr_d = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
      end
      ACCESS: begin
        mem_en = 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESPOND: begin
        rvalid[owner_q] = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      if (take) begin
        owner_q <= win;
        we_q    <= we[win];
        addr_q  <= addr[int'(win)*ADDR_W +: ADDR_W];
        wdata_q <= wdata[int'(win)*32 +: 32];
        wmask_q <= wmask[int'(win)*4 +: 4];
      end
      if (state_q == ACCESS && cnt_q == LAST && !we_q)
        rdata_q <= mem_rdata;
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      lock_q <= 1'b0;
    else if (state_q == RESPOND)
      lock_q <= lock[owner_q];
    else if (take)
      lock_q <= 1'b0;
  end
`endif

  assign rdata     = rdata_q;
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = mem_we ? wmask_q : 4'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter with a small memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata = 32'h0;
`ifdef ARB_LOCK_EN
  logic [1:0]  lock = 2'b00;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(32), .MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .wmask(wmask),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:63];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  typedef struct {
    logic [1:0]  req, we;
    logic [31:0] a0, a1, wd1;
    logic [3:0]  wm0, wm1;
    logic [1:0]  gnt, rv;
    logic [31:0] rdata;
    logic        en, mwe;
    logic [3:0]  mwm;
    logic [31:0] maddr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic [1:0] r, input logic [1:0] w, input logic [31:0] a0,
    input logic [31:0] a1, input logic [31:0] wd1, input logic [3:0] wm0,
    input logic [3:0] wm1, input logic [1:0] g, input logic [1:0] rv,
    input logic [31:0] rd, input logic en, input logic mwe,
    input logic [3:0] mwm, input logic [31:0] ma);
    vec_t t;
    t.req = r; t.we = w; t.a0 = a0; t.a1 = a1; t.wd1 = wd1;
    t.wm0 = wm0; t.wm1 = wm1; t.gnt = g; t.rv = rv; t.rdata = rd;
    t.en = en; t.mwe = mwe; t.mwm = mwm; t.maddr = ma;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input string nm, input logic [1:0] r,
                     input logic [1:0] eg, input logic [1:0] erv);
    @(negedge clk);
    req = r;
    #1;
    chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
    chk({nm, "_rvalid"}, 32'(rvalid), 32'(erv));
  endtask

  initial begin
    reset = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0; wmask = '0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    //          req   we    a0     a1     wd1           wm0 wm1  gnt   rv    rdata         en mwe mwm maddr
    tbl.push_back(v(2'b00,2'b00,32'h00,32'h00,32'h0,       4'h0,4'h0,2'b00,2'b00,32'h0,       0,0,4'h0,32'h0));
    tbl.push_back(v(2'b01,2'b00,32'h10,32'h00,32'h0,       4'hF,4'h0,2'b01,2'b00,32'h0,       0,0,4'h0,32'h0));
    tbl.push_back(v(2'b00,2'b00,32'h00,32'h00,32'h0,       4'h0,4'h0,2'b00,2'b00,32'h0,       1,0,4'h0,32'h10));
    tbl.push_back(v(2'b00,2'b00,32'h00,32'h00,32'h0,       4'h0,4'h0,2'b00,2'b00,32'h0,       1,0,4'h0,32'h10));
    tbl.push_back(v(2'b10,2'b10,32'h00,32'h20,32'h12345678,4'h0,4'hF,2'b00,2'b01,32'hDEADBEEF,0,0,4'h0,32'h0));
    tbl.push_back(v(2'b10,2'b10,32'h00,32'h20,32'h12345678,4'h0,4'hF,2'b10,2'b00,32'hDEADBEEF,0,0,4'h0,32'h0));
    tbl.push_back(v(2'b00,2'b00,32'h00,32'h99,32'h0,       4'h0,4'h0,2'b00,2'b00,32'hDEADBEEF,1,1,4'hF,32'h20));
    tbl.push_back(v(2'b00,2'b00,32'h00,32'h99,32'h0,       4'h0,4'h0,2'b00,2'b00,32'hDEADBEEF,1,1,4'hF,32'h20));
    tbl.push_back(v(2'b00,2'b00,32'h00,32'h00,32'h0,       4'h0,4'h0,2'b00,2'b10,32'hDEADBEEF,0,0,4'h0,32'h0));
    tbl.push_back(v(2'b10,2'b00,32'h00,32'h20,32'h0,       4'h0,4'hF,2'b10,2'b00,32'hDEADBEEF,0,0,4'h0,32'h0));
    tbl.push_back(v(2'b00,2'b00,32'h00,32'h00,32'h0,       4'h0,4'h0,2'b00,2'b00,32'hDEADBEEF,1,0,4'h0,32'h20));
    tbl.push_back(v(2'b00,2'b00,32'h00,32'h00,32'h0,       4'h0,4'h0,2'b00,2'b00,32'hDEADBEEF,1,0,4'h0,32'h20));
    tbl.push_back(v(2'b00,2'b00,32'h00,32'h00,32'h0,       4'h0,4'h0,2'b00,2'b10,32'h12345678,0,0,4'h0,32'h0));
    tbl.push_back(v(2'b00,2'b00,32'h00,32'h00,32'h0,       4'h0,4'h0,2'b00,2'b00,32'h12345678,0,0,4'h0,32'h0));
    tbl.push_back(v(2'b11,2'b00,32'h10,32'h20,32'h0,       4'h0,4'h0,2'b01,2'b00,32'h12345678,0,0,4'h0,32'h0));
    tbl.push_back(v(2'b11,2'b00,32'h10,32'h20,32'h0,       4'h0,4'h0,2'b00,2'b00,32'h12345678,1,0,4'h0,32'h10));
    tbl.push_back(v(2'b11,2'b00,32'h10,32'h20,32'h0,       4'h0,4'h0,2'b00,2'b00,32'h12345678,1,0,4'h0,32'h10));
    tbl.push_back(v(2'b11,2'b00,32'h10,32'h20,32'h0,       4'h0,4'h0,2'b00,2'b01,32'hDEADBEEF,0,0,4'h0,32'h0));
    tbl.push_back(v(2'b11,2'b00,32'h10,32'h20,32'h0,       4'h0,4'h0,2'b10,2'b00,32'hDEADBEEF,0,0,4'h0,32'h0));
    tbl.push_back(v(2'b11,2'b00,32'h10,32'h20,32'h0,       4'h0,4'h0,2'b00,2'b00,32'hDEADBEEF,1,0,4'h0,32'h20));
    tbl.push_back(v(2'b11,2'b00,32'h10,32'h20,32'h0,       4'h0,4'h0,2'b00,2'b00,32'hDEADBEEF,1,0,4'h0,32'h20));
    tbl.push_back(v(2'b11,2'b00,32'h10,32'h20,32'h0,       4'h0,4'h0,2'b00,2'b10,32'h12345678,0,0,4'h0,32'h0));
    tbl.push_back(v(2'b11,2'b00,32'h10,32'h20,32'h0,       4'h0,4'h0,2'b01,2'b00,32'h12345678,0,0,4'h0,32'h0));
    tbl.push_back(v(2'b00,2'b00,32'h00,32'h00,32'h0,       4'h0,4'h0,2'b00,2'b00,32'h12345678,1,0,4'h0,32'h10));
    tbl.push_back(v(2'b00,2'b00,32'h00,32'h00,32'h0,       4'h0,4'h0,2'b00,2'b00,32'h12345678,1,0,4'h0,32'h10));
    tbl.push_back(v(2'b00,2'b00,32'h00,32'h00,32'h0,       4'h0,4'h0,2'b00,2'b01,32'hDEADBEEF,0,0,4'h0,32'h0));
    tbl.push_back(v(2'b00,2'b00,32'h00,32'h00,32'h0,       4'h0,4'h0,2'b00,2'b00,32'hDEADBEEF,0,0,4'h0,32'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      req   = tbl[i].req;
      we    = tbl[i].we;
      addr  = {tbl[i].a1, tbl[i].a0};
      wdata = {tbl[i].wd1, 32'h0};
      wmask = {tbl[i].wm1, tbl[i].wm0};
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
      chk($sformatf("v%0d_rdata", i), rdata, tbl[i].rdata);
      chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(tbl[i].en));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].mwe));
      chk($sformatf("v%0d_mem_wmask", i), 32'(mem_wmask), 32'(tbl[i].mwm));
      if (tbl[i].en)
        chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].maddr);
    end

    // reset in the second ACCESS cycle of a write; rr_ptr is 1 here
    @(negedge clk);
    req = 2'b01; we = 2'b01; addr = {32'h0, 32'h10};
    wdata = {32'h0, 32'hCAFEF00D}; wmask = 8'h0F;
    #1;
    chk("rw_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 2'b00; we = 2'b00;
    #1;
    chk("rw_acc1_we", 32'(mem_we), 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rw_abort_en", 32'(mem_en), 0);
    chk("rw_abort_rv", 32'(rvalid), 0);
    chk("rw_abort_rdata", rdata, 0);
    @(negedge clk);
    #1;
    chk("rw_hold_rv", 32'(rvalid), 0);
    chk("rw_hold_en", 32'(mem_en), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rw_idle_gnt", 32'(gnt), 0);
    chk("rw_idle_rv", 32'(rvalid), 0);
    cyc("post_rst", 2'b11, 2'b01, 2'b00);
    cyc("post_acc1", 2'b00, 2'b00, 2'b00);
    cyc("post_acc2", 2'b00, 2'b00, 2'b00);
    cyc("post_resp", 2'b00, 2'b00, 2'b01);
    cyc("post_idle", 2'b00, 2'b00, 2'b00);

`ifdef ARB_LOCK_EN
    cyc("lk_g1", 2'b11, 2'b10, 2'b00);
    cyc("lk_a1", 2'b11, 2'b00, 2'b00);
    cyc("lk_a2", 2'b11, 2'b00, 2'b00);
    cyc("lk_r1", 2'b11, 2'b00, 2'b10);
    lock = 2'b01;
    cyc("lk_g0", 2'b11, 2'b01, 2'b00);
    cyc("lk_a3", 2'b11, 2'b00, 2'b00);
    cyc("lk_a4", 2'b11, 2'b00, 2'b00);
    cyc("lk_r0", 2'b11, 2'b00, 2'b01);
    cyc("lk_again0", 2'b11, 2'b01, 2'b00);
    lock = 2'b00;
    cyc("lk_a5", 2'b11, 2'b00, 2'b00);
    cyc("lk_a6", 2'b11, 2'b00, 2'b00);
    cyc("lk_r2", 2'b11, 2'b00, 2'b01);
    cyc("lk_g1b", 2'b11, 2'b10, 2'b00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
